// File: rtl/store_rmw_ctrl.sv
// Store sequencer for a word-only data memory: sub-word stores become a
// read-modify-write, aligned word stores are written directly.
module store_rmw_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_req_i,
    output logic        st_ready_o,
    input  logic [31:0] st_addr_i,
    input  logic [31:0] st_data_i,
    input  logic [1:0]  st_size_i,
    output logic        st_done_o,
    output logic        st_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_strb_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // The counter only has to reach TIMEOUT-1; the timeout fires on that cycle.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   lane_mask = 4'b0001 << off;
            2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   lane_data = {4{data[7:0]}};
            2'b01:   lane_data = {2{data[15:0]}};
            default: lane_data = data;
        endcase
    endfunction

    function automatic logic [31:0] expand_mask(input logic [3:0] m);
        expand_mask = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    state_t           state_q, state_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_strb_q, mem_strb_d;
    logic [31:0]      lane_q, lane_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ack_s;
    logic             tmo_s;

    // An ack only counts against an outstanding request; ack beats timeout.
    assign ack_s = mem_req_q & mem_ack_i;
    assign tmo_s = (TIMEOUT != 32'd0) && mem_req_q && !mem_ack_i && (cnt_q == CNT_LAST);

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_strb_d  = mem_strb_q;
        lane_d      = lane_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (st_req_i) begin
                    mem_addr_d = {st_addr_i[31:2], 2'b00};
                    mem_strb_d = lane_mask(st_size_i, st_addr_i[1:0]);
                    lane_d     = lane_data(st_size_i, st_data_i);
                    cnt_d      = '0;
                    if (misaligned(st_size_i, st_addr_i[1:0])) begin
                        state_d = S_ERR;
                    end else if (st_size_i == 2'b10) begin
                        state_d     = S_WR;
                        mem_wdata_d = st_data_i;
                    end else begin
                        state_d = S_RD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (ack_s) begin
                    mem_wdata_d = (mem_rdata_i & ~expand_mask(mem_strb_q))
                                | (lane_q & expand_mask(mem_strb_q));
                    cnt_d       = '0;
                    state_d     = S_WR;
                end else if (tmo_s) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    mem_req_d = 1'b1;
                    cnt_d     = mem_req_q ? cnt_q + CNT_W'(1) : cnt_q;
                end
            end
            S_WR: begin
                if (ack_s) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (tmo_s) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b1;
                    cnt_d     = mem_req_q ? cnt_q + CNT_W'(1) : cnt_q;
                end
            end
            S_ERR: begin
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_strb_q  <= 4'd0;
            lane_q      <= 32'd0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_strb_q  <= mem_strb_d;
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign st_ready_o  = (state_q == S_IDLE);
    assign st_done_o   = done_q;
    assign st_err_o    = err_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_strb_o  = mem_strb_q;

endmodule

// File: doc/store_rmw_ctrl.md
Name: store_rmw_ctrl

Overview:
- Sequences CPU stores (SB/SH/SW) onto a word-wide data memory that has no byte-write capability.
- Sub-word stores run a read-modify-write: read the word, merge the byte/half lane, write the word back. Aligned word stores write directly.
- Sits between the LSU store path and the data-memory port, and replaces the combinational lane masking on the store path with a sequenced merge.
- Flags misaligned stores and memory timeouts.

Parameters:
- TIMEOUT, 16, max cycles to wait for mem_ack in a memory phase; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- st_req  in  1  store request, sampled only when st_ready=1
- st_ready  out  1  high in IDLE; request accepted when st_req&st_ready
- st_addr  in  32  byte address of store
- st_data  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- st_size  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as misaligned)
- st_done  out  1  one-cycle pulse: store committed to memory
- st_err  out  1  one-cycle pulse: misaligned/reserved size or timeout; no further memory access for that store
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1=write, 0=read; valid while mem_req=1
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  out  32  merged write word; valid while mem_req&mem_we
- mem_strb  out  4  byte lanes modified by the current store (informational, debug/trace)
- mem_rdata  in  32  read data, valid in the mem_ack cycle of a read
- mem_ack  in  1  one-cycle completion strobe for the current request

Behaviour:
- Reset values (sync, rst=1 at edge):
  - state=IDLE.
  - mem_req, mem_we, st_done, st_err = 0.
  - mem_addr, mem_wdata, mem_strb = 0.
  - timeout counter = 0.
  - st_ready is combinational (state==IDLE), so it reads 1 after reset.
- Reset mid-operation: the next edge forces IDLE. mem_req drops that cycle and no done/err pulse is produced. A mem_ack arriving after reset is ignored.
- States: IDLE, RD, WR, ERR.
- IDLE, on accept:
  - Register addr, data and size.
  - Compute lane mask M (4 bits):
    - byte: 1<<addr[1:0]
    - half: addr[1] ? 1100 : 0011
    - word: 1111
  - Misaligned means any of: half with addr[0]=1; word with addr[1:0]!=0; size=11.
  - Misaligned -> ERR. Word -> WR. Byte/half -> RD.
  - mem_addr and mem_strb are registered on accept.
- Lane data L:
  - byte: {4{data[7:0]}}
  - half: {2{data[15:0]}}
  - word: data
- RD: mem_req=1, mem_we=0.
  - On mem_ack, register mem_wdata = (mem_rdata & ~E) | (L & E), where E is M expanded to bit mask (each mask bit -> 8 bits).
  - Then go to WR.
- WR: mem_req=1, mem_we=1.
  - For a word store, mem_wdata = data, registered on accept.
  - On mem_ack -> IDLE, with st_done=1 in the following cycle (registered pulse).
- mem_req is registered. It rises the cycle after entering RD/WR. It is deasserted in the cycle after mem_ack, including between RD and WR (at least one idle cycle between read and write).
- ERR: st_err=1 for exactly one cycle, then IDLE. No mem_req is ever issued for the failed store.
- Timeout:
  - The counter resets to 0 on entering RD or WR and increments each cycle mem_req=1 without mem_ack.
  - If TIMEOUT>0 and the count reaches TIMEOUT with no ack, then: mem_req drops, st_err pulses once, state goes to IDLE, and the store is abandoned.
  - If mem_ack and the timeout coincide in the same cycle, the ack wins.
- Latency with single-cycle ack:
  - Word store: accept -> st_done in 3 cycles.
  - Sub-word store: accept -> st_done in 5 cycles.
- Back-to-back requests: a new store may be accepted in the cycle st_done or st_err is high, because state is already IDLE.
- st_req while st_ready=0 is ignored. The requester must hold st_req and all store fields until accepted.
- mem_ack while mem_req=0 is ignored.
- st_done and st_err are never high in the same cycle.

Test Plan:
- Reset: rst=1 for 2 cycles -> st_ready=1, mem_req=0, st_done=0, st_err=0, mem_wdata=0.
- SW aligned: addr=0x100, data=0xDEADBEEF, ack next cycle -> one write only, mem_addr=0x100, mem_wdata=0xDEADBEEF, mem_strb=1111, st_done 3 cycles after accept.
- SB RMW: addr=0x203, data=0x000000AB, mem_rdata=0x11223344 -> read 0x200, then write 0xAB223344, mem_strb=1000, st_done once.
- SH RMW upper lane: addr=0x202, data=0x0000CAFE, mem_rdata=0x11223344 -> write 0xCAFE3344.
- SH RMW lower lane: addr=0x200, same data and rdata -> write 0x1122CAFE.
- Misaligned: SH addr=0x201, SW addr=0x102, and size=11 -> each gives an st_err pulse, no mem_req, st_ready=1 the next cycle.
- Timeout: TIMEOUT=4, SB with mem_ack held 0 -> mem_req high 4 cycles then low, one st_err pulse, no write issued.
- Ack/timeout collision: ack on the 4th cycle -> ack wins, no st_err.
- Reset mid-RD: assert rst while mem_req=1 -> next cycle IDLE, mem_req=0, no st_done/st_err. A following SW completes normally.
